// File: rtl/fft_consts_pkg.sv
// Shared FFT constants, complex sample type, AGU state encoding and the
// butterfly address helper used by the address generation unit.
package fft_consts;

  localparam int N          = 8;
  localparam int N_LOG2     = 3;
  localparam int S_W        = $clog2(N_LOG2);
  localparam int K_W        = N_LOG2 - 1;
  localparam int DW         = 16;
  localparam int DW_COMPLEX = 2 * DW;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } agu_state_t;

  typedef struct packed {
    logic [N_LOG2-1:0] a;
    logic [N_LOG2-1:0] b;
    logic [N_LOG2-2:0] tw;
  } bf_addr_t;

  // Butterfly k of stage s: the upper leg keeps the low s bits of k in place
  // and spreads the group index above bit s; the lower leg is 2^s further on.
  function automatic bf_addr_t bf_addr(input logic [S_W-1:0] s,
                                       input logic [K_W-1:0] k);
    bf_addr_t          r;
    logic [N_LOG2-1:0] kx;
    logic [N_LOG2-1:0] mask;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] grp;
    logic [N_LOG2-1:0] twx;
    kx   = {1'b0, k};
    mask = (N_LOG2'(1) << s) - N_LOG2'(1);
    pos  = kx & mask;
    grp  = kx >> s;
    r.a  = (grp << (s + 1'b1)) | pos;
    r.b  = r.a + (N_LOG2'(1) << s);
    twx  = pos << (S_W'(N_LOG2 - 1) - s);
    r.tw = twx[N_LOG2-2:0];
    return r;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle factor ROM, W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) in Q1.15,
// with a registered read (data appears one cycle after addr).
module twiddle_rom
  import fft_consts::*;
(
  input  logic              clk,
  input  logic [N_LOG2-2:0] addr,
  output complex_t          data_out
);

  complex_t data_d;
  complex_t data_q;

  // Table lookup for the addressed twiddle.
  always_comb begin
    data_d = '0;
    unique case (addr)
      2'd0: data_d = '{re: 16'sh7FFF, im: 16'sh0000};
      2'd1: data_d = '{re: 16'sh5A82, im: 16'shA57E};
      2'd2: data_d = '{re: 16'sh0000, im: 16'sh8001};
      2'd3: data_d = '{re: 16'shA57E, im: 16'shA57E};
      default: data_d = '0;
    endcase
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: rtl/fft_agu.sv
// Address generation unit for the in-place radix-2 DIT FFT. Walks every
// stage/butterfly, drives the twiddle ROM address and presents each
// butterfly's data addresses one cycle later, aligned with the ROM output.
module fft_agu
  import fft_consts::*;
#(
  parameter int BF_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [S_W-1:0]    stage_o,
  output logic              last_in_stage
);

  localparam int DCW = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;

  agu_state_t        state_q, state_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bf_valid_q, bf_valid_d;
  logic [N_LOG2-1:0] addr_a_q, addr_a_d;
  logic [N_LOG2-1:0] addr_b_q, addr_b_d;
  logic [S_W-1:0]    stage_q, stage_d;
  logic              last_q, last_d;
  logic [N_LOG2-2:0] tw_q, tw_d;
  logic              fire;
  bf_addr_t          bf;

  // Next-state, issue and output-register logic. On a stall the ROM keeps
  // being addressed with the presented entry's twiddle so data_out holds.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    k_d         = k_q;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bf_valid_d  = bf_valid_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    stage_d     = stage_q;
    last_d      = last_q;
    tw_d        = tw_q;

    bf      = bf_addr(s_q, k_q);
    fire    = (state_q == RUN) && (!bf_valid_q || bf_ready);
    tw_addr = fire ? bf.tw : tw_q;

    if (fire) begin
      bf_valid_d = 1'b1;
      addr_a_d   = bf.a;
      addr_b_d   = bf.b;
      stage_d    = s_q;
      last_d     = (k_q == K_W'(N / 2 - 1));
      tw_d       = bf.tw;
    end else if (bf_ready) begin
      bf_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (fire) begin
          if (k_q == K_W'(N / 2 - 1)) begin
            k_d         = '0;
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Write-back barrier: the next stage reads what this one writes.
        if (!bf_valid_q) begin
          if (drain_cnt_q == DCW'(BF_LAT)) begin
            drain_cnt_d = '0;
            if (s_q < S_W'(N_LOG2 - 1)) begin
              s_d     = s_q + 1'b1;
              state_d = RUN;
            end else begin
              state_d = FINISH;
            end
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        s_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bf_valid_q  <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      stage_q     <= '0;
      last_q      <= 1'b0;
      tw_q        <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bf_valid_q  <= bf_valid_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      stage_q     <= stage_d;
      last_q      <= last_d;
      tw_q        <= tw_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bf_valid      = bf_valid_q;
  assign addr_a        = addr_a_q;
  assign addr_b        = addr_b_q;
  assign stage_o       = stage_q;
  assign last_in_stage = last_q;

endmodule

// File: tb/tb_fft_agu.sv
// Bench for fft_agu with the twiddle ROM attached: scoreboard of the
// golden N=8 butterfly list, consumed by a monitor on every handshake.
module tb_fft_agu;
  import fft_consts::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [N_LOG2-2:0] tw_addr;
  logic              bf_valid;
  logic              bf_ready;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [S_W-1:0]    stage_o;
  logic              last_in_stage;
  complex_t          data_out;

  fft_agu #(.BF_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .tw_addr(tw_addr), .bf_valid(bf_valid), .bf_ready(bf_ready),
    .addr_a(addr_a), .addr_b(addr_b), .stage_o(stage_o),
    .last_in_stage(last_in_stage)
  );

  twiddle_rom rom (.clk(clk), .addr(tw_addr), .data_out(data_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
    bit last;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   gap = 0;
  bit   gap_pend = 0;

  int ga [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int gb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int gtw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  logic [31:0] rom_exp[4] = '{32'h7FFF_0000, 32'h5A82_A57E,
                              32'h0000_8001, 32'hA57E_A57E};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_golden();
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      e.a = ga[i]; e.b = gb[i]; e.tw = gtw[i]; e.s = i / 4; e.last = (i % 4) == 3;
      sb_q.push_back(e);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd) bf_ready = 1'($urandom_range(0, 1));
      if (done) begin seen = 1; break; end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: done not seen within %0d cycles", budget);
    end
    bf_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input int h0, input int d0);
    check({tag, "_bf_count"}, 32'(hs_cnt - h0), 32'd12);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bf_valid"}, 32'(bf_valid), 32'd0);
    check({tag, "_last"}, 32'(last_in_stage), 32'd0);
    check({tag, "_addr_a"}, 32'(addr_a), 32'd0);
    check({tag, "_addr_b"}, 32'(addr_b), 32'd0);
    check({tag, "_stage"}, 32'(stage_o), 32'd0);
    check({tag, "_tw_addr"}, 32'(tw_addr), 32'd0);
  endtask

  // Monitor: one scoreboard entry per consumed butterfly, done pulses and
  // the idle gap between the last butterfly of a stage and the next one.
  always @(negedge clk) begin
    if (!rst_n) begin
      gap_pend = 0;
      gap = 0;
    end else begin
      if (done) begin
        done_cnt++;
        tests++;
        if (busy) begin
          fails++;
          $display("FAIL done_busy: busy=%0d while done, expected 0", busy);
        end
      end
      if (gap_pend) begin
        if (bf_valid) begin
          tests++;
          if (gap < 4) begin
            fails++;
            $display("FAIL stage_gap: %0d idle cycles, expected >= 4", gap);
          end
          gap_pend = 0;
        end else begin
          gap++;
        end
      end
      if (bf_valid && bf_ready) begin
        hs_cnt++;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL extra_bf: a=%0d b=%0d with empty scoreboard", addr_a, addr_b);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (int'(addr_a) != e.a || int'(addr_b) != e.b || int'(stage_o) != e.s ||
              last_in_stage != e.last || data_out !== rom_exp[e.tw]) begin
            fails++;
            $display("FAIL bf_entry: got a=%0d b=%0d s=%0d last=%0d data=%h expected a=%0d b=%0d s=%0d last=%0d data=%h",
                     addr_a, addr_b, stage_o, last_in_stage, data_out,
                     e.a, e.b, e.s, e.last, rom_exp[e.tw]);
          end
          if (e.last && e.s < N_LOG2 - 1) begin
            gap_pend = 1;
            gap = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  h0;
    int  d0;
    bit  found;
    rst_n = 1'b0;
    start = 1'b0;
    bf_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back transform, with first-butterfly latency.
    push_golden();
    h0 = hs_cnt; d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_cycle1_valid", 32'(bf_valid), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 32'(bf_valid), 32'd1);
    check("first_addr_a", 32'(addr_a), 32'd0);
    check("first_addr_b", 32'(addr_b), 32'd1);
    wait_done(0, 300);
    check_run("run1", h0, d0);

    // Stall on stage 1, k=1; start re-pulsed while busy.
    push_golden();
    h0 = hs_cnt; d0 = done_cnt;
    start_pulse();
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bf_valid && stage_o == 1 && addr_a == 1) begin found = 1; break; end
      @(posedge clk); #1;
    end
    check("stall_target_found", 32'(found), 32'd1);
    bf_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("stall_valid", 32'(bf_valid), 32'd1);
      check("stall_addr_a", 32'(addr_a), 32'd1);
      check("stall_addr_b", 32'(addr_b), 32'd3);
      check("stall_tw_addr", 32'(tw_addr), 32'd2);
      check("stall_data", data_out, rom_exp[2]);
    end
    bf_ready = 1'b1;
    wait_done(0, 300);
    check_run("stall_run", h0, d0);

    // Asynchronous reset in the middle of stage 1.
    push_golden();
    start_pulse();
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bf_valid && stage_o == 1) begin found = 1; break; end
      @(posedge clk); #1;
    end
    check("rst_target_found", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    sb_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    // Clean transform after reset.
    push_golden();
    h0 = hs_cnt; d0 = done_cnt;
    start_pulse();
    wait_done(0, 300);
    check_run("post_rst", h0, d0);

    // Random backpressure.
    push_golden();
    h0 = hs_cnt; d0 = done_cnt;
    start_pulse();
    wait_done(1, 2000);
    check_run("rand", h0, d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
